// File: rtl/branch_predictor_v2_pkg.sv
// Shared constants for the branch predictor: default PC width, history-mode
// encodings and the PHT counter reset value.
package branch_predictor_v2_pkg;

  localparam int unsigned BP_ADDR_WIDTH     = 32;
  localparam int unsigned PRED_MODE_LOCAL   = 0;
  localparam int unsigned PRED_MODE_GSELECT = 1;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int unsigned ctr_weak_nt(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_v2_sat_counter_next.sv
// Next value of an up/down saturating counter (combinational).
module sat_counter_next #(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr_i,
  input  logic                 inc_i,
  output logic [CTR_WIDTH-1:0] ctr_next_c_o
);

  always_comb begin
    ctr_next_c_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != '1) ctr_next_c_o = ctr_i + CTR_WIDTH'(1);
    end else begin
      if (ctr_i != '0) ctr_next_c_o = ctr_i - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_v2.sv
// Conditional-branch predictor: PHT indexed by {idx, local or global history},
// tagged BTB for next-PC, registered query response, ROB-commit training.
module branch_predictor_v2
  import branch_predictor_v2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = BP_ADDR_WIDTH,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned HIST_WIDTH  = 4,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned MODE        = PRED_MODE_LOCAL
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  query_en,
  input  logic [ADDR_WIDTH-1:0] query_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic                  pred_hit,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_en,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  output logic [31:0]           mispred_cnt
);

  localparam int unsigned PHT_AW  = INDEX_WIDTH + HIST_WIDTH;
  localparam int unsigned NUM_IDX = 1 << INDEX_WIDTH;
  localparam int unsigned NUM_PHT = 1 << PHT_AW;
  localparam int unsigned TAG_HI  = INDEX_WIDTH + TAG_WIDTH;
  localparam bit          GLOBAL  = (MODE == PRED_MODE_GSELECT);
  localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(ctr_weak_nt(CTR_WIDTH));

  logic [CTR_WIDTH-1:0]  pht_q        [NUM_PHT];
  logic [HIST_WIDTH-1:0] bht_q        [NUM_IDX];
  logic                  btb_valid_q  [NUM_IDX];
  logic [TAG_WIDTH-1:0]  btb_tag_q    [NUM_IDX];
  logic [ADDR_WIDTH-1:0] btb_target_q [NUM_IDX];
  logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic                  pred_hit_q, pred_hit_d;
  logic [ADDR_WIDTH-1:0] pred_target_q, pred_target_d;
  logic [31:0]           mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_WIDTH-1:0] q_idx, u_idx;
  logic [TAG_WIDTH-1:0]   q_tag, u_tag;
  logic [HIST_WIDTH-1:0]  q_hist, u_hist, u_hist_nxt;
  logic [CTR_WIDTH-1:0]   q_ctr, u_ctr, u_ctr_nxt;
  logic [PHT_AW-1:0]      u_addr;
  logic                   q_hit, upd_fire;
  logic                   unused_pc_bits;

  assign q_idx  = query_pc[INDEX_WIDTH:1];
  assign q_tag  = query_pc[TAG_HI:INDEX_WIDTH+1];
  assign q_hist = GLOBAL ? ghr_q : bht_q[q_idx];
  assign q_ctr  = pht_q[{q_idx, q_hist}];
  assign q_hit  = btb_valid_q[q_idx] && (btb_tag_q[q_idx] == q_tag);

  assign upd_fire   = upd_en && rdy_in;
  assign u_idx      = upd_pc[INDEX_WIDTH:1];
  assign u_tag      = upd_pc[TAG_HI:INDEX_WIDTH+1];
  assign u_hist     = GLOBAL ? ghr_q : bht_q[u_idx];
  assign u_addr     = {u_idx, u_hist};
  assign u_ctr      = pht_q[u_addr];
  assign u_hist_nxt = {u_hist[HIST_WIDTH-2:0], upd_taken};

  assign unused_pc_bits = ^{query_pc[0], query_pc[ADDR_WIDTH-1:TAG_HI+1],
                            upd_pc[0], upd_pc[ADDR_WIDTH-1:TAG_HI+1]};

  sat_counter_next #(.CTR_WIDTH(CTR_WIDTH)) u_upd_ctr (
    .ctr_i        (u_ctr),
    .inc_i        (upd_taken),
    .ctr_next_c_o (u_ctr_nxt)
  );

  // Response and counter next-state; rdy_in low freezes everything.
  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_hit_d    = pred_hit_q;
    pred_target_d = pred_target_q;
    mispred_cnt_d = mispred_cnt_q;
    ghr_d         = ghr_q;
    if (rdy_in) begin
      pred_valid_d = query_en;
      if (query_en) begin
        pred_hit_d    = q_hit;
        pred_taken_d  = q_hit && q_ctr[CTR_WIDTH-1];
        pred_target_d = q_hit ? btb_target_q[q_idx] : '0;
      end
    end
    if (upd_fire) begin
      if (GLOBAL) ghr_d = u_hist_nxt;
      if (upd_mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Table writes sit after the query read, so same-cycle queries see old data.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_target_q <= '0;
      mispred_cnt_q <= '0;
      ghr_q         <= '0;
      pht_q         <= '{default: CTR_RST};
      bht_q         <= '{default: '0};
      btb_valid_q   <= '{default: 1'b0};
      btb_tag_q     <= '{default: '0};
      btb_target_q  <= '{default: '0};
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_hit_q    <= pred_hit_d;
      pred_target_q <= pred_target_d;
      mispred_cnt_q <= mispred_cnt_d;
      ghr_q         <= ghr_d;
      if (upd_fire) begin
        pht_q[u_addr] <= u_ctr_nxt;
        if (!GLOBAL) bht_q[u_idx] <= u_hist_nxt;
        if (upd_taken) begin
          btb_valid_q[u_idx]  <= 1'b1;
          btb_tag_q[u_idx]    <= u_tag;
          btb_target_q[u_idx] <= upd_target;
        end
      end
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_hit    = pred_hit_q;
  assign pred_target = pred_target_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_v2.sv
// Scoreboard bench: a local-history and a gselect instance share one directed
// stimulus stream; hand-computed responses are queued per instance.
module tb_branch_predictor_v2;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  localparam exp_t MISS  = '{hit: 1'b0, taken: 1'b0, target: 32'h0};
  localparam exp_t HT200 = '{hit: 1'b1, taken: 1'b1, target: 32'h200};
  localparam exp_t HN200 = '{hit: 1'b1, taken: 1'b0, target: 32'h200};
  localparam exp_t HN400 = '{hit: 1'b1, taken: 1'b0, target: 32'h400};

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, query_en, upd_en, upd_taken, upd_mispredict;
  logic [31:0] query_pc, upd_pc, upd_target;

  logic        l_valid, l_taken, l_hit, g_valid, g_taken, g_hit;
  logic [31:0] l_target, g_target, l_cnt, g_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t q_l[$];
  exp_t q_g[$];

  always #5 clk = ~clk;

  branch_predictor_v2 #(.MODE(0)) dut_l (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .query_en(query_en), .query_pc(query_pc),
    .pred_valid(l_valid), .pred_taken(l_taken), .pred_hit(l_hit), .pred_target(l_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispred_cnt(l_cnt)
  );

  branch_predictor_v2 #(.MODE(1)) dut_g (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .query_en(query_en), .query_pc(query_pc),
    .pred_valid(g_valid), .pred_taken(g_taken), .pred_hit(g_hit), .pred_target(g_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispred_cnt(g_cnt)
  );

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_pop(input bit glob, input exp_t act);
    exp_t e;
    string name;
    name = glob ? "resp_gselect" : "resp_local";
    if ((glob ? q_g.size() : q_l.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected actual=%0h expected=none at %0t", name, act, $time);
    end else begin
      e = glob ? q_g.pop_front() : q_l.pop_front();
      chk(name, 34'(act), 34'(e));
    end
  endtask

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    if (!rst_in && l_valid) mon_pop(1'b0, '{hit: l_hit, taken: l_taken, target: l_target});
    if (!rst_in && g_valid) mon_pop(1'b1, '{hit: g_hit, taken: g_taken, target: g_target});
  end

  task automatic step();
    @(posedge clk);
    #1;
    query_en       = 1'b0;
    upd_en         = 1'b0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc, input exp_t el, input exp_t eg);
    query_en = 1'b1;
    query_pc = pc;
    q_l.push_back(el);
    q_g.push_back(eg);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
    upd_en         = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mp;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_l"}, 34'(l_valid), 34'd0);
    chk({tag, "_hit_l"}, 34'(l_hit), 34'd0);
    chk({tag, "_taken_l"}, 34'(l_taken), 34'd0);
    chk({tag, "_target_l"}, 34'(l_target), 34'd0);
    chk({tag, "_cnt_l"}, 34'(l_cnt), 34'd0);
    chk({tag, "_valid_g"}, 34'(g_valid), 34'd0);
    chk({tag, "_hit_g"}, 34'(g_hit), 34'd0);
    chk({tag, "_taken_g"}, 34'(g_taken), 34'd0);
    chk({tag, "_target_g"}, 34'(g_target), 34'd0);
    chk({tag, "_cnt_g"}, 34'(g_cnt), 34'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; query_en = 1'b0; query_pc = '0;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_in = 1'b0;

    query(32'h100, MISS, MISS); step();
    // Same-cycle query reads the pre-update BTB; the next one hits.
    upd(32'h100, 1'b1, 32'h200, 1'b1); query(32'h100, MISS, MISS); step();
    upd(32'h100, 1'b1, 32'h200, 1'b0); query(32'h100, HN200, HN200); step();
    repeat (3) begin upd(32'h100, 1'b1, 32'h200, 1'b0); step(); end
    query(32'h100, HT200, HT200); step();

    // Saturate {0,1111} at 11, then one not-taken brings it to 10.
    repeat (4) begin upd(32'h100, 1'b1, 32'h200, 1'b0); step(); end
    query(32'h100, HT200, HT200); step();
    upd(32'h100, 1'b0, 32'h0, 1'b1); step();
    repeat (4) begin upd(32'h340, 1'b1, 32'h400, 1'b0); step(); end
    query(32'h100, HN200, HT200); step();
    query(32'h340, HN400, HN400); step();
    step();
    chk("mispred_cnt_l", 34'(l_cnt), 34'd2);
    chk("mispred_cnt_g", 34'(g_cnt), 34'd2);

    // rdy_in low: update, mispredict and query are all ignored; outputs hold.
    rdy_in = 1'b0;
    upd(32'h180, 1'b1, 32'h999, 1'b1); query_en = 1'b1; query_pc = 32'h100;
    step();
    upd(32'h180, 1'b1, 32'h999, 1'b1);
    step();
    chk("stall_cnt_l", 34'(l_cnt), 34'd2);
    chk("stall_cnt_g", 34'(g_cnt), 34'd2);
    chk("stall_valid_l", 34'(l_valid), 34'd0);
    chk("stall_hit_hold_l", 34'(l_hit), 34'd1);
    chk("stall_target_hold_g", 34'(g_target), 34'h400);
    rdy_in = 1'b1;
    query(32'h180, MISS, MISS); step();
    query(32'h100, HN200, HT200); step();
    step();

    // Asynchronous reset while an update is being presented.
    upd(32'h340, 1'b1, 32'h400, 1'b1);
    #3 rst_in = 1'b1;
    #1 chk_zero("async_reset");
    step();
    rst_in = 1'b0;
    query(32'h100, MISS, MISS); step();

    // Global-history training sequence.
    upd(32'h100, 1'b1, 32'h200, 1'b0); step();
    upd(32'h340, 1'b0, 32'h0, 1'b1); step();
    query(32'h100, HN200, HN200); step();
    upd(32'h100, 1'b1, 32'h200, 1'b0); step();
    upd(32'h340, 1'b0, 32'h0, 1'b0); step();
    upd(32'h340, 1'b0, 32'h0, 1'b0); step();
    upd(32'h340, 1'b1, 32'h400, 1'b0); step();
    upd(32'h340, 1'b0, 32'h0, 1'b0); step();
    query(32'h100, HN200, HT200); step();
    query(32'h340, HN400, HN400); step();
    query(32'h180, MISS, MISS); step();
    step();
    step();
    chk("final_cnt_l", 34'(l_cnt), 34'd1);
    chk("final_cnt_g", 34'(g_cnt), 34'd1);
    chk("queue_l_drained", 34'(q_l.size()), 34'd0);
    chk("queue_g_drained", 34'(q_g.size()), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
